// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB initiator: FSM state encoding,
// default ACCESS-phase timeout and a counter-width helper.
package apb_initiator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   // The timeout counter only has to reach max_count-1, so $clog2 is enough.
   function automatic int cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/apb_initiator_if.sv
// APB bus bundle between the initiator (master modport) and a completer
// (slave modport). Signal names keep the initiator-side direction suffixes.
interface apb_initiator_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] paddr_o;
   logic [DATA_WIDTH-1:0] pwdata_o;
   logic                  pwrite_o;
   logic                  psel_o;
   logic                  penable_o;
   logic [DATA_WIDTH-1:0] prdata_i;
   logic                  pready_i;
   logic                  pslverr_i;

   modport master (
      output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
      input  prdata_i, pready_i, pslverr_i
   );

   modport slave (
      input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
      output prdata_i, pready_i, pslverr_i
   );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter, only instantiated when APB_INITIATOR_TIMEOUT_EN
// is defined. expired_o flags the terminal-count cycle.
module apb_timeout_cnt
   import apb_initiator_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt <= '0;
      end else if (inc_i) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Terminal count: the TIMEOUT_CYCLES-th ACCESS cycle without pready.
   assign expired_o = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator bridging a req/gnt core port to APB.
// Optional ACCESS timeout enabled by defining APB_INITIATOR_TIMEOUT_EN.
module apb_initiator
   import apb_initiator_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   // Core side: a request transfers on a cycle where req_i && gnt_o; req_i
   // may be held and its payload is only sampled in that cycle. The response
   // is a one-cycle rvalid_o pulse with no back-pressure; rdata_o/err_o hold.
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [APB_ADDR_WIDTH-1:0] addr_i,
   input  logic [APB_DATA_WIDTH-1:0] wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [APB_DATA_WIDTH-1:0] rdata_o,
   output logic                      err_o,
   apb_initiator_if.master           apb,
   output apb_state_e                state_dbg
);

   apb_state_e state;
   apb_state_e state_next;

   logic                      psel_q;
   logic                      penable_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [APB_DATA_WIDTH-1:0] pwdata_q;
   logic                      pwrite_q;
   logic                      rvalid_q;
   logic [APB_DATA_WIDTH-1:0] rdata_q;
   logic                      err_q;
   logic                      timeout;

`ifdef APB_INITIATOR_TIMEOUT_EN
   logic expired;

   // Cleared during SETUP so the count starts at zero on ACCESS entry.
   apb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (state == ST_SETUP),
      .inc_i     ((state == ST_ACCESS) && !apb.pready_i),
      .expired_o (expired)
   );

   // pready in the terminal-count cycle wins over the timeout.
   assign timeout = expired && !apb.pready_i;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (req_i) begin
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (apb.pready_i || timeout) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign gnt_o = req_i && (state == ST_IDLE);

   // Bus controls are registered from the next state so they switch on the
   // same edge as the FSM without a decode path to the pins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
      end else begin
         psel_q    <= (state_next != ST_IDLE);
         penable_q <= (state_next == ST_ACCESS);
         if (gnt_o) begin
            paddr_q  <= addr_i;
            pwdata_q <= wdata_i;
            pwrite_q <= we_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         if (state == ST_ACCESS) begin
            if (apb.pready_i) begin
               rvalid_q <= 1'b1;
               err_q    <= apb.pslverr_i;
               rdata_q  <= pwrite_q ? '0 : apb.prdata_i;
            end else if (timeout) begin
               rvalid_q <= 1'b1;
               err_q    <= 1'b1;
               rdata_q  <= '0;
            end
         end
      end
   end

   assign apb.paddr_o   = paddr_q;
   assign apb.pwdata_o  = pwdata_q;
   assign apb.pwrite_o  = pwrite_q;
   assign apb.psel_o    = psel_q;
   assign apb.penable_o = penable_q;

   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench for apb_initiator: planned transactions drive an APB
// completer model; expected responses and their cycles are queued at grant.
module tb_apb_initiator;
   import apb_initiator_pkg::*;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int TO    = 8;
   localparam int NEVER = 1 << 30;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            waits;
      logic [DW-1:0] prdata;
      logic          slverr;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;
   logic          err;
   apb_state_e    state_dbg;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int free_cyc = 0;

   txn_t          plan_q[$];
   logic [DW:0]   exp_q[$];
   int            exp_cyc_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   apb_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   apb_initiator #(
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .we_i      (we),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .gnt_o     (gnt),
      .rvalid_o  (rvalid),
      .rdata_o   (rdata),
      .err_o     (err),
      .apb       (apb.master),
      .state_dbg (state_dbg)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: outcome of a transfer from its plan alone.
   function automatic bit times_out(input txn_t t);
`ifdef APB_INITIATOR_TIMEOUT_EN
      return t.waits >= TO;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit rsp_expected(input txn_t t);
      return times_out(t) || (t.waits < NEVER);
   endfunction

   function automatic int model_lat(input txn_t t);
      return times_out(t) ? (2 + TO) : (3 + t.waits);
   endfunction

   function automatic logic [DW:0] model_rsp(input txn_t t);
      if (times_out(t)) return {1'b1, {DW{1'b0}}};
      return {t.slverr, (t.we ? {DW{1'b0}} : t.prdata)};
   endfunction

   function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int ws, input logic [DW-1:0] rd, input logic se);
      txn_t t;
      t.we = w; t.addr = a; t.wdata = d; t.waits = ws; t.prdata = rd; t.slverr = se;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      return mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 5),
                $urandom, ($urandom_range(0, 3) == 0));
   endfunction

   // Driver: call just after a rising edge; returns just after a rising edge.
   task automatic issue(input txn_t t);
      int  waited = 0;
      bit  got = 1'b0;
      req = 1'b1; we = t.we; addr = t.addr; wdata = t.wdata;
      forever begin
         @(negedge clk);
         chk("gnt", gnt, (cyc >= free_cyc));
         if (gnt) begin
            got = 1'b1;
            break;
         end
         waited++;
         if (waited > 300) begin
            n_tests++; n_fail++;
            $display("FAIL gnt_wait: no grant after %0d cycles, required a grant", waited);
            break;
         end
         @(posedge clk); #1;
      end
      if (got) begin
         plan_q.push_back(t);
         if (rsp_expected(t)) begin
            exp_q.push_back(model_rsp(t));
            exp_cyc_q.push_back(cyc + model_lat(t));
            free_cyc = cyc + model_lat(t);
         end else begin
            free_cyc = cyc + NEVER;
         end
      end
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   // APB completer model: follows the plan queue, checks address phase.
   txn_t cur;
   int   left = 0;
   bit   have = 1'b0;
   bit   was_setup = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         apb.pready_i = 1'b0; apb.pslverr_i = 1'b0; apb.prdata_i = '0;
         have = 1'b0; was_setup = 1'b0;
         plan_q.delete();
      end else begin
         if (was_setup) chk("setup_one_cycle", {apb.psel_o, apb.penable_o}, 2'b11);
         was_setup = 1'b0;
         apb.pready_i  = 1'b0;
         apb.pslverr_i = 1'($urandom_range(0, 1));
         apb.prdata_i  = $urandom;
         if (apb.psel_o && !apb.penable_o) begin
            if (plan_q.size() == 0) begin
               chk("setup_without_txn", 1'b1, 1'b0);
            end else begin
               cur = plan_q.pop_front();
               left = cur.waits; have = 1'b1; was_setup = 1'b1;
               chk("setup_paddr", apb.paddr_o, cur.addr);
               chk("setup_pwrite", apb.pwrite_o, cur.we);
               chk("setup_pwdata", apb.pwdata_o, cur.wdata);
            end
         end else if (apb.psel_o && apb.penable_o && have) begin
            chk("access_paddr_stable", apb.paddr_o, cur.addr);
            chk("access_pwrite_stable", apb.pwrite_o, cur.we);
            chk("access_pwdata_stable", apb.pwdata_o, cur.wdata);
            if (left == 0) begin
               apb.pready_i = 1'b1; apb.prdata_i = cur.prdata; apb.pslverr_i = cur.slverr;
               have = 1'b0;
            end else begin
               left--;
            end
         end
      end
   end

   // Response monitor.
   logic [DW-1:0] last_rdata = '0;
   logic          last_err = 1'b0;

   always @(negedge clk) begin
      logic [DW:0] e;
      int          ec;
      if (rst) begin
         exp_q.delete(); exp_cyc_q.delete();
         last_rdata = '0; last_err = 1'b0;
      end else begin
         if (rvalid) begin
            if (exp_q.size() == 0) begin
               chk("rvalid_unexpected", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               chk("rsp_rdata", rdata, e[DW-1:0]);
               chk("rsp_err", err, e[DW]);
               chk("rsp_cycle", cyc, ec);
               last_rdata = e[DW-1:0]; last_err = e[DW];
            end
         end else begin
            chk("rdata_hold", rdata, last_rdata);
            chk("err_hold", err, last_err);
         end
         if (!req) chk("gnt_no_req", gnt, 1'b0);
      end
   end

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      free_cyc = 0;
   endtask

   initial begin
      int held;
      int d;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_psel", apb.psel_o, 1'b0);
      chk("rst_penable", apb.penable_o, 1'b0);
      chk("rst_rvalid", rvalid, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_rdata", rdata, '0);
      chk("rst_paddr", apb.paddr_o, '0);
      chk("rst_pwdata", apb.pwdata_o, '0);
      chk("rst_pwrite", apb.pwrite_o, 1'b0);
      chk("rst_gnt", gnt, 1'b0);
      chk("rst_state", state_dbg, ST_IDLE);
      @(posedge clk); #1;
      rst = 1'b0;
      free_cyc = 0;

      issue(mk(1'b0, 32'h1A10_2000, 32'h0, 0, 32'hDEAD_BEEF, 1'b0));
      issue(mk(1'b1, 32'h1A10_0004, 32'h0000_00FF, 3, 32'h1234_5678, 1'b0));
      issue(mk(1'b0, 32'h1A10_0008, 32'h0, 1, 32'hCAFE_0001, 1'b1));

      for (int i = 0; i < 3; i++) begin
         issue(mk(1'(i), 32'h1A10_1000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i),
                  0, 32'h600D_0000 + 32'(i), 1'b0));
      end

      for (int i = 0; i < 40; i++) begin
         issue(rand_txn());
         if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
            end
         end
      end

      issue(mk(1'b0, 32'h1A10_3000, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0));

`ifdef APB_INITIATOR_TIMEOUT_EN
      issue(mk(1'b0, 32'h1A10_3004, 32'h0, NEVER, 32'h5555_5555, 1'b0));
      issue(mk(1'b1, 32'h1A10_3008, 32'h77, 2, 32'h0, 1'b0));
`else
      issue(mk(1'b0, 32'h1A10_3004, 32'h0, NEVER, 32'h5555_5555, 1'b0));
      held = 0;
      repeat (100) begin
         @(negedge clk);
         if (apb.psel_o) held++;
      end
      chk("hang_psel_held", held, 100);
      @(posedge clk); #1;
      do_reset(2);
`endif

      // Reset in ACCESS aborts the transfer without a response.
      issue(mk(1'b0, 32'h1A10_4000, 32'h0, 20, 32'h1111_2222, 1'b0));
      @(posedge clk); #1;
      chk("abort_in_access", state_dbg, ST_ACCESS);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_psel", apb.psel_o, 1'b0);
      chk("abort_penable", apb.penable_o, 1'b0);
      chk("abort_rvalid", rvalid, 1'b0);
      chk("abort_rdata", rdata, '0);
      chk("abort_state", state_dbg, ST_IDLE);
      rst = 1'b0;
      free_cyc = 0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      issue(mk(1'b0, 32'h1A10_4004, 32'h0, 1, 32'h3333_4444, 1'b0));

      d = 0;
      while (exp_q.size() != 0 && d < 300) begin
         @(posedge clk);
         d++;
      end
      chk("drain_empty", exp_q.size(), 0);
      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_tests++; n_fail++;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase wait cycles.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_i  in  1  core request valid.
REQ-007 SHALL have port we_i  in  1  request is write.
REQ-008 SHALL have port addr_i  in  APB_ADDR_WIDTH  request address.
REQ-009 SHALL have port wdata_i  in  APB_DATA_WIDTH  write data.
REQ-010 SHALL have port gnt_o  out  1  request accepted this cycle.
REQ-011 SHALL have port rvalid_o  out  1  response valid, one-cycle pulse.
REQ-012 SHALL have port rdata_o  out  APB_DATA_WIDTH  read data.
REQ-013 SHALL have port err_o  out  1  response error, qualified by rvalid_o.
REQ-014 SHALL have APB master ports paddr_o, pwdata_o (out, widths per parameters), pwrite_o, psel_o, penable_o (out, 1), prdata_i (in, APB_DATA_WIDTH), pready_i, pslverr_i (in, 1).

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS; one transfer outstanding at most.
REQ-016 gnt_o SHALL equal req_i AND (state == IDLE), combinationally; no other output combinational.
REQ-017 On grant SHALL register addr_i, wdata_i, we_i into paddr_o, pwdata_o, pwrite_o and move IDLE->SETUP.
REQ-018 SETUP SHALL drive psel_o=1, penable_o=0 for exactly one cycle, then ->ACCESS.
REQ-019 ACCESS SHALL drive psel_o=1, penable_o=1 until pready_i=1 sampled, then ->IDLE.
REQ-020 paddr_o, pwdata_o, pwrite_o SHALL remain stable from SETUP through final ACCESS cycle.
REQ-021 On completion SHALL pulse rvalid_o next cycle; rdata_o=prdata_i for reads, 0 for writes; err_o=pslverr_i.
REQ-022 Minimum latency: grant cycle N, SETUP N+1, ACCESS N+2 (pready=1), rvalid_o N+3.
REQ-023 Grant SHALL be possible in the same cycle rvalid_o is high (back-to-back, one idle bus cycle).
REQ-024 psel_o and penable_o SHALL be 0 in IDLE.
REQ-025 rdata_o and err_o SHALL hold last values until next response.

Reset
REQ-026 rst_i=1 SHALL force state IDLE, psel_o=0, penable_o=0, rvalid_o=0, err_o=0, rdata_o=0, paddr_o=0, pwdata_o=0, pwrite_o=0, timeout count=0.
REQ-027 Reset during SETUP/ACCESS SHALL abort transfer at next edge; no rvalid_o for it.

Configuration
REQ-028 With macro APB_INITIATOR_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles without pready_i; on reaching TIMEOUT_CYCLES SHALL end transfer (->IDLE, psel_o=0) and pulse rvalid_o with err_o=1, rdata_o=0.
REQ-029 Counter SHALL clear on entering ACCESS; pready_i in the terminal count cycle completes normally.
REQ-030 Without APB_INITIATOR_TIMEOUT_EN, ACCESS SHALL wait indefinitely; no counter logic present.

Structure
REQ-031 State enum typedef and default timeout constant SHALL live in package apb_initiator_pkg.
REQ-032 Timeout counter SHALL be sub-module apb_timeout_cnt, instantiated only under APB_INITIATOR_TIMEOUT_EN.

Verification
REQ-033 Read 0x1A10_2000, pready=1 at once, prdata=0xDEADBEEF -> SETUP/ACCESS one cycle each, rvalid at grant+3, rdata 0xDEADBEEF, err 0.
REQ-034 Write 0x1A10_0004 data 0x0000_00FF, pready after 3 wait cycles -> penable high 4 cycles, pwdata stable, rvalid rdata 0.
REQ-035 Read with pslverr=1 on completion -> rvalid with err 1.
REQ-036 req_i held high for 3 transfers -> gnt in IDLE only, one idle bus cycle between, responses in order.
REQ-037 Macro defined, TIMEOUT_CYCLES=8, pready never -> rvalid err 1 after 8 ACCESS cycles; macro undefined -> psel held high 100 cycles, no rvalid.
REQ-038 rst_i asserted in ACCESS -> psel/penable 0 next cycle, no rvalid; next request completes normally.
